// File: rtl/seg7_scroll_ctrl.sv
// seg7_scroll_ctrl: Avalon-MM slave that scrolls a 6-character window of a
// 16-entry character buffer across the DE1-SoC HEX5..HEX0 displays, with an
// optional blink phase. All outputs are registered.
module seg7_scroll_ctrl #(
    parameter int unsigned DEFAULT_PERIOD = 50000000,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned NUM_DIGITS     = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [6:0]  hex0_n,
    output logic [6:0]  hex1_n,
    output logic [6:0]  hex2_n,
    output logic [6:0]  hex3_n,
    output logic [6:0]  hex4_n,
    output logic [6:0]  hex5_n
);

    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_LEN    = 5'h01;
    localparam logic [4:0] ADDR_PERIOD = 5'h02;
    localparam logic [4:0] ADDR_STATUS = 5'h03;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    logic [1:0]  r_ctrl;
    logic [4:0]  r_len;
    logic [31:0] r_period;
    logic [4:0]  r_char [MAX_LEN];
    logic [3:0]  r_offset;
    logic [31:0] r_cnt;
    logic        r_phase;
    logic [31:0] r_readdata;
    logic [6:0]  r_hex [NUM_DIGITS];

    logic        w_wr_ctrl;
    logic        w_wr_len;
    logic        w_wr_period;
    logic        w_wr_char;
    logic        w_restart;
    logic        w_run;
    logic        w_tick;
    logic        w_blink_off;
    logic [31:0] w_rdata;
    logic [3:0]  w_idx [NUM_DIGITS];

    // Active-low segment code for one character; bit4 set means blank.
    function automatic logic [6:0] seg_enc(input logic [4:0] c);
        logic [6:0] s;
        case (c[3:0])
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return c[4] ? SEG_BLANK : s;
    endfunction

    assign w_wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign w_wr_len    = avs_write && (avs_address == ADDR_LEN);
    assign w_wr_period = avs_write && (avs_address == ADDR_PERIOD);
    assign w_wr_char   = avs_write && avs_address[4];
    assign w_restart   = w_wr_len || w_wr_period;
    assign w_run       = r_ctrl[0] || r_ctrl[1];
    assign w_tick      = w_run && (r_cnt == r_period - 32'd1);
    // Phase is held at 0 while blink is off, including the edge that clears it.
    assign w_blink_off = !r_ctrl[1] || (w_wr_ctrl && !avs_writedata[1]);

    // Configuration registers and character buffer, with write clamping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl   <= 2'b00;
            r_len    <= 5'd6;
            r_period <= 32'(DEFAULT_PERIOD);
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                r_char[i] <= 5'h10;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= avs_writedata[1:0];
            end
            if (w_wr_len) begin
                if (avs_writedata == 32'd0) begin
                    r_len <= 5'd1;
                end else if (avs_writedata > 32'(MAX_LEN)) begin
                    r_len <= 5'(MAX_LEN);
                end else begin
                    r_len <= avs_writedata[4:0];
                end
            end
            if (w_wr_period) begin
                r_period <= (avs_writedata == 32'd0) ? 32'd1 : avs_writedata;
            end
            if (w_wr_char) begin
                r_char[avs_address[3:0]] <= avs_writedata[4:0];
            end
        end
    end

    // Period timer, scroll offset and blink phase; LEN/PERIOD writes restart all three.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 32'd0;
            r_offset <= 4'd0;
            r_phase  <= 1'b0;
        end else begin
            if (w_restart || !w_run || w_tick) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (w_restart) begin
                r_offset <= 4'd0;
            end else if (w_tick && r_ctrl[0]) begin
                r_offset <= ({1'b0, r_offset} == r_len - 5'd1) ? 4'd0 : r_offset + 4'd1;
            end

            if (w_restart || w_blink_off) begin
                r_phase <= 1'b0;
            end else if (w_tick) begin
                r_phase <= !r_phase;
            end
        end
    end

    // Read mux; unmapped addresses return 0.
    always_comb begin
        w_rdata = 32'd0;
        case (avs_address)
            ADDR_CTRL:   w_rdata = {30'd0, r_ctrl};
            ADDR_LEN:    w_rdata = {27'd0, r_len};
            ADDR_PERIOD: w_rdata = r_period;
            ADDR_STATUS: w_rdata = {23'd0, r_phase, 4'd0, r_offset};
            default: begin
                if (avs_address[4]) begin
                    w_rdata = {27'd0, r_char[avs_address[3:0]]};
                end
            end
        endcase
    end

    // Registered read data, latency 1; a same-cycle write is not seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else if (avs_read) begin
            r_readdata <= w_rdata;
        end
    end

    // Window indices: HEX5 shows CHAR[offset], each digit to the right steps
    // one character forward, wrapping at LEN (offset is always below LEN).
    always_comb begin
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            w_idx[k] = 4'd0;
        end
        w_idx[NUM_DIGITS-1] = r_offset;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            w_idx[k-1] = ({1'b0, w_idx[k]} == r_len - 5'd1) ? 4'd0 : w_idx[k] + 4'd1;
        end
    end

    // Segment output registers; blank during the blink-off phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                r_hex[k] <= SEG_BLANK;
            end
        end else begin
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                r_hex[k] <= r_phase ? SEG_BLANK : seg_enc(r_char[w_idx[k]]);
            end
        end
    end

    assign avs_readdata = r_readdata;
    assign hex0_n = r_hex[0];
    assign hex1_n = r_hex[1];
    assign hex2_n = r_hex[2];
    assign hex3_n = r_hex[3];
    assign hex4_n = r_hex[4];
    assign hex5_n = r_hex[5];

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Testbench for seg7_scroll_ctrl: directed scenarios followed by random
// register traffic, checked against an arithmetic reference model through a
// scoreboard queue drained by an independent monitor.
module tb_seg7_scroll_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [6:0]  hex0_n, hex1_n, hex2_n, hex3_n, hex4_n, hex5_n;

    always #5 clk = ~clk;

    seg7_scroll_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .hex0_n       (hex0_n),
        .hex1_n       (hex1_n),
        .hex2_n       (hex2_n),
        .hex3_n       (hex3_n),
        .hex4_n       (hex4_n),
        .hex5_n       (hex5_n)
    );

    typedef struct {
        bit [41:0] hex;
        bit        has_rd;
        bit [31:0] rd;
    } exp_t;

    exp_t q_exp [$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    bit [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int unsigned m_ctrl, m_len, m_period, m_off, m_cnt, m_phase;
    int unsigned m_char [16];

    function automatic bit [41:0] dut_hex();
        return {hex5_n, hex4_n, hex3_n, hex2_n, hex1_n, hex0_n};
    endfunction

    task automatic check(input string name, input bit [63:0] act, input bit [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_len = 6; m_period = 50000000;
        m_off = 0; m_cnt = 0; m_phase = 0;
        for (int i = 0; i < 16; i++) m_char[i] = 'h10;
    endtask

    function automatic bit [41:0] model_hex();
        bit [41:0] v;
        for (int k = 0; k < 6; k++) begin
            int unsigned c;
            bit [6:0] d;
            c = m_char[(m_off + 5 - k) % m_len];
            if (m_phase != 0 || c >= 16) d = 7'h7F;
            else d = seg_tab[c];
            v[k*7 +: 7] = d;
        end
        return v;
    endfunction

    function automatic bit [31:0] model_read(input bit [4:0] a);
        if (a == 0) return m_ctrl;
        if (a == 1) return m_len;
        if (a == 2) return m_period;
        if (a == 3) return (m_phase << 8) | m_off;
        if (a >= 16) return m_char[a - 16];
        return 0;
    endfunction

    // One clock edge of the specified behaviour, from pre-edge state and inputs.
    task automatic model_step(input bit wr, input bit [4:0] a, input bit [31:0] wd);
        bit run, tick, restart, blink_on_after;
        int unsigned new_ctrl;
        run      = (m_ctrl != 0);
        tick     = run && (m_cnt == m_period - 1);
        restart  = wr && (a == 1 || a == 2);
        new_ctrl = (wr && a == 0) ? (wd & 3) : m_ctrl;
        blink_on_after = ((m_ctrl & 2) != 0) && ((new_ctrl & 2) != 0);

        if (restart || !run || tick) m_cnt = 0;
        else m_cnt = m_cnt + 1;

        if (restart) m_off = 0;
        else if (tick && (m_ctrl & 1)) m_off = (m_off + 1) % m_len;

        if (restart || !blink_on_after) m_phase = 0;
        else if (tick) m_phase = 1 - m_phase;

        if (wr) begin
            if (a == 0) m_ctrl = wd & 3;
            else if (a == 1) m_len = (wd == 0) ? 1 : (wd > 16) ? 16 : wd;
            else if (a == 2) m_period = (wd == 0) ? 1 : wd;
            else if (a >= 16) m_char[a - 16] = wd & 'h1F;
        end
    endtask

    // Drive one bus cycle (called at a falling edge), record expectations at the edge.
    task automatic do_cycle(input bit wr, input bit [4:0] a, input bit [31:0] wd, input bit rd);
        exp_t e;
        avs_write = wr; avs_address = a; avs_writedata = wd; avs_read = rd;
        @(posedge clk);
        e.hex    = model_hex();
        e.has_rd = rd;
        e.rd     = rd ? model_read(a) : 32'd0;
        q_exp.push_back(e);
        model_step(wr, a, wd);
        mon_en = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 5'd0, 32'd0, 0);
    endtask

    // Monitor: every falling edge the DUT presents hex outputs, and read data
    // for the previous cycle's read; compare against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q_exp.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = q_exp.pop_front();
                    check("hex", dut_hex(), e.hex);
                    if (e.has_rd) check("readdata", avs_readdata, e.rd);
                end
            end
        end
    end

    initial begin
        bit [4:0]  a;
        bit [31:0] d;
        int        guard;

        // 1. reset state
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        check("rst_hex", dut_hex(), {6{7'h7F}});
        check("rst_readdata", avs_readdata, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_cycle(0, 5'h00, 0, 1);
        do_cycle(0, 5'h01, 0, 1);
        check("len_reset", avs_readdata, 6);
        do_cycle(0, 5'h02, 0, 1);
        check("period_reset", avs_readdata, 50000000);
        do_cycle(0, 5'h03, 0, 1);
        check("status_reset", avs_readdata, 0);
        do_cycle(0, 5'h07, 0, 1);
        do_cycle(0, 5'h10, 0, 1);

        // 2. static characters
        for (int i = 0; i < 6; i++) do_cycle(1, 5'(16 + i), i, 0);
        do_cycle(1, 5'h00, 0, 0);
        idle(1);
        check("static_window", dut_hex(), {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        do_cycle(0, 5'h03, 0, 1);

        // 3. scrolling over 8 characters
        do_cycle(1, 5'h01, 8, 0);
        do_cycle(1, 5'h16, 'hA, 0);
        do_cycle(1, 5'h17, 'hF, 0);
        do_cycle(1, 5'h02, 4, 0);
        do_cycle(1, 5'h00, 1, 0);
        guard = 0;
        while (m_off != 7 && guard < 100) begin idle(1); guard++; end
        check("reach_offset7", guard < 100, 1);
        idle(1);
        check("off7_hex5", hex5_n, 7'h0E);
        check("off7_hex4", hex4_n, 7'h40);
        check("off7_hex0", hex0_n, 7'h19);
        idle(12);
        do_cycle(0, 5'h03, 0, 1);

        // 4. clamping
        do_cycle(1, 5'h01, 0, 0);
        do_cycle(0, 5'h01, 0, 1);
        check("len_clamp0", avs_readdata, 1);
        do_cycle(1, 5'h01, 31, 0);
        do_cycle(0, 5'h01, 0, 1);
        check("len_clamp31", avs_readdata, 16);
        do_cycle(1, 5'h02, 0, 0);
        do_cycle(0, 5'h02, 0, 1);
        check("period_clamp0", avs_readdata, 1);
        for (int i = 0; i < 4; i++) do_cycle(0, 5'h03, 0, 1);

        // 5. blink
        do_cycle(1, 5'h01, 6, 0);
        do_cycle(1, 5'h00, 2, 0);
        do_cycle(1, 5'h02, 3, 0);
        idle(14);
        do_cycle(1, 5'h00, 0, 0);
        do_cycle(0, 5'h03, 0, 1);
        check("blink_cleared_phase", avs_readdata[8], 0);
        idle(2);

        // 6. LEN write in a tick cycle, then reset mid-scroll
        do_cycle(1, 5'h02, 2, 0);
        do_cycle(1, 5'h00, 1, 0);
        idle(3);
        guard = 0;
        while (!(m_cnt == m_period - 1 && m_off != 0) && guard < 50) begin idle(1); guard++; end
        check("reach_tick", guard < 50, 1);
        do_cycle(1, 5'h01, 6, 0);
        do_cycle(0, 5'h03, 0, 1);
        check("len_in_tick_offset", avs_readdata[3:0], 0);
        idle(5);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_hex", dut_hex(), {6{7'h7F}});
        check("midrst_readdata", avs_readdata, 0);
        q_exp.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        do_cycle(0, 5'h00, 0, 1);
        do_cycle(0, 5'h01, 0, 1);
        do_cycle(0, 5'h02, 0, 1);
        do_cycle(0, 5'h03, 0, 1);
        do_cycle(0, 5'h12, 0, 1);

        // Random register traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 18) begin
                do_cycle(1, 5'(16 + $urandom_range(0, 15)), $urandom, $urandom_range(0, 1));
            end else if (r < 24) begin
                do_cycle(1, 5'h00, $urandom_range(0, 3), 0);
            end else if (r < 27) begin
                do_cycle(1, 5'h01, $urandom_range(0, 40), 0);
            end else if (r < 30) begin
                do_cycle(1, 5'h02, $urandom_range(0, 6), 0);
            end else if (r < 33) begin
                a = 5'($urandom_range(3, 15));
                do_cycle(1, a, $urandom, 1);
            end else if (r < 50) begin
                do_cycle(0, 5'($urandom_range(0, 31)), 0, 1);
            end else if (r < 55) begin
                a = 5'(16 + $urandom_range(0, 15));
                d = $urandom;
                do_cycle(1, a, d, 1);
            end else begin
                do_cycle(0, 5'h03, 0, $urandom_range(0, 1));
            end
        end

        idle(2);
        check("scoreboard_drained", q_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
